// File: rtl/degamma_2_0.sv
// rtl/degamma_2_0.sv - gamma 2.0 decode: 12-bit encoded RGB to 8-bit linear, 3-stage pipeline
//
// Purpose: out = min(255, floor(in^2 / 65536)) per channel, one pixel per clock, no
// backpressure. Syncs ride alongside the data. A bypass mode, latched once per frame on
// the vs rising edge, substitutes truncation in[11:4] for the squaring path.
//
// Ports:
//   I_clk, I_rst_n          pixel clock, asynchronous active-low reset
//   I_bypass                bypass request, sampled only at frame start
//   I_vs, I_hs, I_de        input syncs / data enable
//   I_r, I_g, I_b           gamma-encoded components (IN_W bits)
//   O_vs, O_hs, O_de        syncs delayed by 3 cycles
//   O_r, O_g, O_b           linear components (OUT_W bits), 0 when O_de is low
//   O_bypass_active         bypass state latched for the current frame
module degamma_2_0 #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 8,
  parameter int SHIFT = 16
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_bypass,
  input  logic             I_vs,
  input  logic             I_hs,
  input  logic             I_de,
  input  logic [IN_W-1:0]  I_r,
  input  logic [IN_W-1:0]  I_g,
  input  logic [IN_W-1:0]  I_b,
  output logic             O_vs,
  output logic             O_hs,
  output logic             O_de,
  output logic [OUT_W-1:0] O_r,
  output logic [OUT_W-1:0] O_g,
  output logic [OUT_W-1:0] O_b,
  output logic             O_bypass_active
);

  localparam int PW = 2 * IN_W;
  localparam logic [PW-1:0] OUT_MAX = PW'((1 << OUT_W) - 1);

  // Squared value scaled down and saturated; the clamp only matters if the
  // parameters are changed so that p >> SHIFT can exceed the output range.
  function automatic logic [OUT_W-1:0] linearise(input logic [PW-1:0] p);
    logic [PW-1:0] q;
    q = p >> SHIFT;
    if (q > OUT_MAX) return {OUT_W{1'b1}};
    return q[OUT_W-1:0];
  endfunction

  logic [IN_W-1:0]  in_px  [3];
  logic [OUT_W-1:0] out_px [3];

  assign in_px[0] = I_r;
  assign in_px[1] = I_g;
  assign in_px[2] = I_b;
  assign O_r = out_px[0];
  assign O_g = out_px[1];
  assign O_b = out_px[2];

  // Frame-level bypass latch. vs_d resets to 1 so a vs already high when reset
  // is released is not mistaken for a new frame.
  logic vs_d;
  logic frame_bypass;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vs_d         <= 1'b1;
      frame_bypass <= 1'b0;
    end else begin
      vs_d <= I_vs;
      if (I_vs && !vs_d) frame_bypass <= I_bypass;
    end
  end

  assign O_bypass_active = frame_bypass;

  // Stage 1: capture inputs and the bypass tag in force before any update on
  // this same edge, so the first pixel of a frame uses the previous latch.
  logic            s1_vs, s1_hs, s1_de, s1_tag;
  logic [IN_W-1:0] s1_px [3];

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      s1_vs  <= 1'b0;
      s1_hs  <= 1'b0;
      s1_de  <= 1'b0;
      s1_tag <= 1'b0;
      for (int c = 0; c < 3; c++) s1_px[c] <= '0;
    end else begin
      s1_vs  <= I_vs;
      s1_hs  <= I_hs;
      s1_de  <= I_de;
      s1_tag <= frame_bypass;
      for (int c = 0; c < 3; c++) s1_px[c] <= in_px[c];
    end
  end

  // Stage 2: square each channel; the truncated value travels alongside for
  // the bypass path.
  logic             s2_vs, s2_hs, s2_de, s2_tag;
  logic [PW-1:0]    s2_sq [3];
  logic [OUT_W-1:0] s2_tr [3];

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      s2_vs  <= 1'b0;
      s2_hs  <= 1'b0;
      s2_de  <= 1'b0;
      s2_tag <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        s2_sq[c] <= '0;
        s2_tr[c] <= '0;
      end
    end else begin
      s2_vs  <= s1_vs;
      s2_hs  <= s1_hs;
      s2_de  <= s1_de;
      s2_tag <= s1_tag;
      for (int c = 0; c < 3; c++) begin
        s2_sq[c] <= PW'(s1_px[c]) * PW'(s1_px[c]);
        s2_tr[c] <= s1_px[c][IN_W-1 -: OUT_W];
      end
    end
  end

  // Stage 3: select linear or truncated value; blank data outside de.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_vs <= 1'b0;
      O_hs <= 1'b0;
      O_de <= 1'b0;
      for (int c = 0; c < 3; c++) out_px[c] <= '0;
    end else begin
      O_vs <= s2_vs;
      O_hs <= s2_hs;
      O_de <= s2_de;
      for (int c = 0; c < 3; c++) begin
        if (!s2_de)      out_px[c] <= '0;
        else if (s2_tag) out_px[c] <= s2_tr[c];
        else             out_px[c] <= linearise(s2_sq[c]);
      end
    end
  end

endmodule
